mips_regfile_sb: RTL and testbench
==================================

# mips_regfile_sb

Parametrised multi-read-port register file with a write-to-read bypass and a per-register busy scoreboard. It serves the pipelined MIPS datapath:
- decode reads operands through N registered read ports;
- writeback writes results;
- issue reserves destination registers so hazard logic can stall on in-flight producers.

Register 0 is hardwired to zero. All state clears on reset.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width; depth is 2**ADDR_W.
- `NUM_RD`, default 2: number of read ports, 1..4.
- `clk` (in, 1): single clock; all state updates on the rising edge.
- `rst_n` (in, 1): reset, asynchronous and active-low.
- `rd_en` (in, NUM_RD): per-port read enable.
- `rd_addr` (in, NUM_RD*ADDR_W): read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- `rd_data` (out, NUM_RD*DATA_W): registered read data; port i occupies bits [i*DATA_W +: DATA_W].
- `rd_busy` (out, NUM_RD): registered busy flag of the addressed register.
- `wr_en` (in, 1): writeback enable.
- `wr_addr` (in, ADDR_W): writeback address.
- `wr_data` (in, DATA_W): writeback data.
- `rsv_en` (in, 1): reserve-destination enable, driven at issue.
- `rsv_addr` (in, ADDR_W): register to mark busy.
- `busy_cnt` (out, ADDR_W+1): number of registers currently busy.

## Operation
- Storage: `regs[0..2**ADDR_W-1]` of DATA_W bits, plus `busy[0..2**ADDR_W-1]`.
- Write: if `wr_en` is high and `wr_addr` != 0, `regs[wr_addr]` <= `wr_data` and `busy[wr_addr]` is cleared.
- Reserve: if `rsv_en` is high and `rsv_addr` != 0, `busy[rsv_addr]` <= 1.
- Reserve and write to the same address in the same cycle: the reserve wins and busy ends at 1 (a newer producer was issued). The data is still written.
- Read port i with `rd_en[i]` high, address a:
  - a == 0: `rd_data` <= 0 and `rd_busy` <= 0.
  - `wr_en` high and `wr_addr` == a != 0: `rd_data` <= `wr_data` (bypass).
  - otherwise: `rd_data` <= `regs[a]`.
  - `rd_busy[i]` <= the next-state busy of a, i.e. the value after this cycle's write-clear and reserve-set.
- Read port with `rd_en[i]` low: `rd_data` and `rd_busy` for that port hold their previous values.
- All read ports are independent; several ports may read the same address in the same cycle.
- Writes to and reserves of address 0 are ignored; `regs[0]` and `busy[0]` are always 0.
- `busy_cnt` is a registered count equal to the population count of `busy` after the update.
  - Per cycle it changes by +1, -1 or 0.
  - Reserving an already-busy register does not increment it.
  - Writing a non-busy register does not decrement it.
  - Range is 0..2**ADDR_W-1.

## Timing
- Read latency is 1 cycle: the address is sampled at edge k, and data and busy are valid after edge k.
- Write latency is 1 cycle: a value written at edge k is readable from storage at edge k+1; at edge k itself it is returned through the bypass.
- Busy-set latency is 1 cycle: a reserve at edge k is visible through `rd_busy` for reads sampled at edge k, because next-state semantics apply.
- Reset (`rst_n` low, asynchronous, any time including mid-operation) forces all of the following to 0 immediately:
  - every entry of `regs`;
  - every entry of `busy`;
  - `rd_data`, `rd_busy` and `busy_cnt`.
- Inputs are ignored while `rst_n` is low. Normal operation resumes at the first rising edge after `rst_n` returns high.
- No combinational path exists from any input to any output.

## Test plan
- Reset then read: write 0xDEADBEEF to r5, assert `rst_n` low mid-cycle, release, read r5 on port 0 → `rd_data` = 0, `rd_busy` = 0, `busy_cnt` = 0.
- Write and bypass: in the same cycle, write r7 = 0x12345678 and read r7 on port 1 → port 1 returns 0x12345678 one cycle later. The next cycle, a read of r7 without a write also returns 0x12345678.
- Zero register:
  - write r0 = 0xFFFFFFFF and reserve r0 in the same cycle;
  - read r0 → `rd_data` = 0, `rd_busy` = 0, `busy_cnt` unchanged.
- Scoreboard:
  - reserve r3, then r4 → `busy_cnt` = 2;
  - reserve r3 again → still 2;
  - write r3 → 1; reading r3 now gives `rd_busy` = 0;
  - reserve r4 and write r4 in the same cycle → r4 stays busy, count stays 1.
- Read enable hold: read r9 = 0x55 on port 0, then drop `rd_en[0]` and write r9 = 0xAA → port 0 still shows 0x55 until `rd_en[0]` is reasserted.
- Parameter sweep:
  - `DATA_W`=16, `ADDR_W`=3, `NUM_RD`=4: all four ports read distinct registers r1..r4 (preloaded 0x0011..0x0044) in the same cycle → the correct values appear on every port;
  - reserve all 7 non-zero registers → `busy_cnt` = 7.

Source files
------------

// File: rtl/mips_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// mips_regfile_sb_if : read/write/reserve bus of the scoreboarded register file
// Revision: 1.0
// ============================================================================
interface mips_regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface
`default_nettype wire

// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// mips_regfile_sb : multi-port register file with write bypass and busy scoreboard
// Revision: 1.0
// ============================================================================
module mips_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [DEPTH-1:0]         busy_q, busy_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RD-1:0]        rd_busy_q, rd_busy_d;

    logic                     w_wr_hit, w_rsv_hit, w_inc, w_dec;
    logic [ADDR_W-1:0]        w_rd_a;

    always_comb begin
        w_wr_hit  = bus.wr_en  && (bus.wr_addr  != '0);
        w_rsv_hit = bus.rsv_en && (bus.rsv_addr != '0);

        // Reserve is applied after the write-clear so a newer producer wins.
        busy_d = busy_q;
        if (w_wr_hit)  busy_d[bus.wr_addr]  = 1'b0;
        if (w_rsv_hit) busy_d[bus.rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;

        w_inc = w_rsv_hit && !busy_q[bus.rsv_addr];
        w_dec = w_wr_hit && busy_q[bus.wr_addr]
                && !(w_rsv_hit && (bus.rsv_addr == bus.wr_addr));
        cnt_d = cnt_q + (ADDR_W+1)'(w_inc) - (ADDR_W+1)'(w_dec);

        rd_data_d = rd_data_q;
        rd_busy_d = rd_busy_q;
        w_rd_a    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_en[i]) begin
                w_rd_a = bus.rd_addr[i*ADDR_W +: ADDR_W];
                if (w_rd_a == '0) begin
                    rd_data_d[i*DATA_W +: DATA_W] = '0;
                    rd_busy_d[i]                  = 1'b0;
                end else begin
                    rd_data_d[i*DATA_W +: DATA_W] =
                        (w_wr_hit && (bus.wr_addr == w_rd_a)) ? bus.wr_data : regs_q[w_rd_a];
                    rd_busy_d[i] = busy_d[w_rd_a];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs_q[j] <= '0;
            end
            busy_q    <= '0;
            cnt_q     <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            if (w_wr_hit) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_busy  = rd_busy_q;
    assign bus.busy_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// tb_mips_regfile_sb : scoreboard bench for two configurations of the register file
// Revision: 1.0
// ============================================================================
module tb_mips_regfile_sb;

    typedef struct packed {
        logic [3:0]      ren;
        logic [3:0][4:0] raddr;
        logic            wen;
        logic [4:0]      waddr;
        logic [31:0]     wdata;
        logic            rsv;
        logic [4:0]      rsvaddr;
    } stim_t;

    typedef struct packed {
        logic [3:0][31:0] rdd;
        logic [3:0]       rdb;
        logic [5:0]       cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    mips_regfile_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) ifb ();

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    mips_regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    // Reference model: plain arrays indexed by configuration (0 = 32/5/2, 1 = 16/3/4).
    logic [31:0] m_regs [2][32];
    logic [31:0] m_busy [2];
    exp_t        m_out  [2];
    exp_t        qa[$], qb[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) m_regs[k][r] = '0;
            m_busy[k] = '0;
            m_out[k]  = '0;
        end
    endtask

    task automatic step(input int k, input stim_t s);
        int aw, nrd, wa, ra, a, c;
        logic [31:0] dmask, wd, nb;
        aw    = (k == 0) ? 5 : 3;
        nrd   = (k == 0) ? 2 : 4;
        dmask = (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        wa    = int'(s.waddr)   % (1 << aw);
        ra    = int'(s.rsvaddr) % (1 << aw);
        wd    = s.wdata & dmask;
        nb    = m_busy[k];
        if (s.wen && wa != 0) nb[wa] = 1'b0;
        if (s.rsv && ra != 0) nb[ra] = 1'b1;
        for (int p = 0; p < nrd; p++) begin
            if (s.ren[p]) begin
                a = int'(s.raddr[p]) % (1 << aw);
                if (a == 0) begin
                    m_out[k].rdd[p] = '0;
                    m_out[k].rdb[p] = 1'b0;
                end else begin
                    m_out[k].rdd[p] = (s.wen && wa == a) ? wd : m_regs[k][a];
                    m_out[k].rdb[p] = nb[a];
                end
            end
        end
        if (s.wen && wa != 0) m_regs[k][wa] = wd;
        m_busy[k] = nb;
        c = 0;
        for (int r = 0; r < 32; r++) c += int'(nb[r]);
        m_out[k].cnt = 6'(c);
    endtask

    task automatic drive(input stim_t sa, input stim_t sb);
        ifa.rd_en    = sa.ren[1:0];
        ifa.rd_addr  = {sa.raddr[1], sa.raddr[0]};
        ifa.wr_en    = sa.wen;
        ifa.wr_addr  = sa.waddr;
        ifa.wr_data  = sa.wdata;
        ifa.rsv_en   = sa.rsv;
        ifa.rsv_addr = sa.rsvaddr;
        ifb.rd_en    = sb.ren;
        ifb.rd_addr  = {sb.raddr[3][2:0], sb.raddr[2][2:0], sb.raddr[1][2:0], sb.raddr[0][2:0]};
        ifb.wr_en    = sb.wen;
        ifb.wr_addr  = sb.waddr[2:0];
        ifb.wr_data  = sb.wdata[15:0];
        ifb.rsv_en   = sb.rsv;
        ifb.rsv_addr = sb.rsvaddr[2:0];
    endtask

    task automatic cycle(input stim_t sa, input stim_t sb);
        @(negedge clk);
        drive(sa, sb);
        step(0, sa);
        step(1, sb);
        qa.push_back(m_out[0]);
        qb.push_back(m_out[1]);
    endtask

    // Reset asserted mid-cycle while garbage traffic is driven; everything must read zero.
    task automatic do_reset();
        stim_t g, z;
        z = '0;
        g = '0;
        g.ren = 4'hF; g.wen = 1'b1; g.waddr = 5'd5; g.wdata = 32'hDEAD_BEEF;
        g.rsv = 1'b1; g.rsvaddr = 5'd6; g.raddr[0] = 5'd5; g.raddr[1] = 5'd5;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        drive(g, g);
        model_reset();
        qa.push_back(m_out[0]);
        qb.push_back(m_out[1]);
        @(negedge clk);
        qa.push_back(m_out[0]);
        qb.push_back(m_out[1]);
        @(negedge clk);
        drive(z, z);
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are presented once per rising edge; compare against the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            for (int p = 0; p < 2; p++) begin
                check($sformatf("A rd_data[%0d]", p), ifa.rd_data[p*32 +: 32], e.rdd[p]);
                check($sformatf("A rd_busy[%0d]", p), 32'(ifa.rd_busy[p]), 32'(e.rdb[p]));
            end
            check("A busy_cnt", 32'(ifa.busy_cnt), 32'(e.cnt));
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            for (int p = 0; p < 4; p++) begin
                check($sformatf("B rd_data[%0d]", p), 32'(ifb.rd_data[p*16 +: 16]), e.rdd[p]);
                check($sformatf("B rd_busy[%0d]", p), 32'(ifb.rd_busy[p]), 32'(e.rdb[p]));
            end
            check("B busy_cnt", 32'(ifb.busy_cnt), 32'(e.cnt));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        stim_t sa, sb, z;
        z = '0;
        model_reset();
        drive(z, z);
        do_reset();

        // Reset clears a prior write
        sa = z; sa.wen = 1; sa.waddr = 5; sa.wdata = 32'hDEAD_BEEF; cycle(sa, z);
        do_reset();
        sa = z; sa.ren[0] = 1; sa.raddr[0] = 5; cycle(sa, z);

        // Bypass, then storage read
        sa = z; sa.wen = 1; sa.waddr = 7; sa.wdata = 32'h1234_5678;
        sa.ren[1] = 1; sa.raddr[1] = 7; cycle(sa, z);
        sa = z; sa.ren[1] = 1; sa.raddr[1] = 7; cycle(sa, z);

        // Register zero ignores write and reserve
        sa = z; sa.wen = 1; sa.waddr = 0; sa.wdata = 32'hFFFF_FFFF; sa.rsv = 1; sa.rsvaddr = 0;
        sa.ren[0] = 1; sa.raddr[0] = 0; cycle(sa, z);
        sa = z; sa.ren[0] = 1; sa.raddr[0] = 0; cycle(sa, z);

        // Scoreboard sequence
        sa = z; sa.rsv = 1; sa.rsvaddr = 3; cycle(sa, z);
        sa = z; sa.rsv = 1; sa.rsvaddr = 4; cycle(sa, z);
        sa = z; sa.rsv = 1; sa.rsvaddr = 3; cycle(sa, z);
        sa = z; sa.wen = 1; sa.waddr = 3; sa.wdata = 32'h33; cycle(sa, z);
        sa = z; sa.ren[0] = 1; sa.raddr[0] = 3; cycle(sa, z);
        sa = z; sa.rsv = 1; sa.rsvaddr = 4; sa.wen = 1; sa.waddr = 4; sa.wdata = 32'h44;
        sa.ren[1] = 1; sa.raddr[1] = 4; cycle(sa, z);

        // Read-enable hold
        sa = z; sa.wen = 1; sa.waddr = 9; sa.wdata = 32'h55; cycle(sa, z);
        sa = z; sa.ren[0] = 1; sa.raddr[0] = 9; cycle(sa, z);
        sa = z; sa.wen = 1; sa.waddr = 9; sa.wdata = 32'hAA; cycle(sa, z);
        cycle(z, z);
        cycle(z, z);
        sa = z; sa.ren[0] = 1; sa.raddr[0] = 9; cycle(sa, z);

        // Narrow, four-port configuration
        for (int r = 1; r <= 4; r++) begin
            sb = z; sb.wen = 1; sb.waddr = 5'(r); sb.wdata = 32'(r * 32'h11); cycle(z, sb);
        end
        sb = z; sb.ren = 4'hF;
        for (int p = 0; p < 4; p++) sb.raddr[p] = 5'(p + 1);
        cycle(z, sb);
        for (int r = 1; r <= 7; r++) begin
            sb = z; sb.rsv = 1; sb.rsvaddr = 5'(r); cycle(z, sb);
        end
        sb = z; sb.ren = 4'hF;
        sb.raddr[0] = 5; sb.raddr[1] = 6; sb.raddr[2] = 7; sb.raddr[3] = 0;
        cycle(z, sb);

        // Randomized traffic with dense address collisions
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            for (int k = 0; k < 2; k++) begin
                stim_t s;
                s = '0;
                s.ren   = 4'($urandom);
                for (int p = 0; p < 4; p++)
                    s.raddr[p] = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
                s.wen     = ($urandom_range(0, 1) == 1);
                s.waddr   = 5'($urandom_range(0, 7));
                s.wdata   = $urandom;
                s.rsv     = ($urandom_range(0, 2) == 0);
                s.rsvaddr = 5'($urandom_range(0, 7));
                if (k == 0) sa = s; else sb = s;
            end
            cycle(sa, sb);
        end

        @(negedge clk);
        @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", qa.size() + qb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
